// File: rtl/bios_boot_select_fsm_if.sv
// rtl/bios_boot_select_fsm_if.sv - signal bundle between the boot-select controller and its surroundings
interface bios_boot_select_fsm_if;
  logic       tick_1ms;
  logic       tick_1s;
  logic       hb_in;
  logic       boot_arm;
  logic       upd_main_n;
  logic       upd_second_n;
  logic       upd_done_n;
  logic       qspi_csn_in;
  logic       qspi_csn0_out;
  logic       qspi_csn1_out;
  logic       por_rst_n;
  logic [1:0] state;
  logic       hb_ok;
  logic       both_fail;

  // Controller side
  modport slave (
    input  tick_1ms, tick_1s, hb_in, boot_arm,
    input  upd_main_n, upd_second_n, upd_done_n, qspi_csn_in,
    output qspi_csn0_out, qspi_csn1_out, por_rst_n, state, hb_ok, both_fail
  );

  // Environment side
  modport master (
    output tick_1ms, tick_1s, hb_in, boot_arm,
    output upd_main_n, upd_second_n, upd_done_n, qspi_csn_in,
    input  qspi_csn0_out, qspi_csn1_out, por_rst_n, state, hb_ok, both_fail
  );
endinterface

// File: rtl/bios_boot_select_fsm.sv
// rtl/bios_boot_select_fsm.sv - dual-BIOS boot select with heartbeat failover, POR pulse and guarded QSPI CS mux
module bios_boot_select_fsm #(
  parameter int unsigned BOOT_WAIT_S  = 150,
  parameter int unsigned HB_LOSS_MS   = 2000,
  parameter int unsigned POR_PULSE_MS = 100
) (
  input  logic                          clk,
  input  logic                          rst_l,
  bios_boot_select_fsm_if.slave         bus
);

  typedef enum logic [1:0] {
    BIOS_MAIN     = 2'd0,
    BIOS_SECOND   = 2'd1,
    UPDATE_MAIN   = 2'd2,
    UPDATE_SECOND = 2'd3
  } state_t;

  localparam logic [11:0] HB_MAX   = 12'(HB_LOSS_MS);
  localparam logic [7:0]  BOOT_MAX = 8'(BOOT_WAIT_S);
  localparam logic [7:0]  POR_MAX  = 8'(POR_PULSE_MS);

  logic        hb_s1, hb_s2, hb_d;
  logic        hb_edge;
  logic [11:0] hb_cnt;
  logic        hb_ok;

  logic [7:0]  boot_cnt;
  logic        boot_done;

  logic        upd_main_d, upd_second_d, upd_done_d;
  logic        fall_main_q, fall_second_q, fall_done_q;

  state_t      state_q, state_d;
  logic        por_issue, por_issue_q;
  logic        both_fail_set, both_fail_q;

  logic        por_rst_n_q;
  logic [7:0]  por_cnt;

  logic        cs_s1, cs_s2, cs_s3;
  logic        sel_req_q, sel_q;

  // Heartbeat synchronizer and edge register
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      hb_s1 <= 1'b0;
      hb_s2 <= 1'b0;
      hb_d  <= 1'b0;
    end else begin
      hb_s1 <= bus.hb_in;
      hb_s2 <= hb_s1;
      hb_d  <= hb_s2;
    end
  end

  assign hb_edge = hb_s2 ^ hb_d;

  // Heartbeat-loss counter: cleared by either edge, saturates at the loss threshold
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      hb_cnt <= HB_MAX;
    end else if (hb_edge) begin
      hb_cnt <= 12'd0;
    end else if (bus.tick_1ms && (hb_cnt < HB_MAX)) begin
      hb_cnt <= hb_cnt + 12'd1;
    end
  end

  assign hb_ok = (hb_cnt < HB_MAX);

  // Boot-wait timer: runs in seconds only while armed and the CPU is out of POR
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      boot_cnt <= 8'd0;
    end else if (!bus.boot_arm || por_issue || por_issue_q) begin
      boot_cnt <= 8'd0;
    end else if (bus.tick_1s && por_rst_n_q && (boot_cnt < BOOT_MAX)) begin
      boot_cnt <= boot_cnt + 8'd1;
    end
  end

  assign boot_done = (boot_cnt == BOOT_MAX);

  // Falling-edge detection of the active-low update request levels
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      upd_main_d    <= 1'b1;
      upd_second_d  <= 1'b1;
      upd_done_d    <= 1'b1;
      fall_main_q   <= 1'b0;
      fall_second_q <= 1'b0;
      fall_done_q   <= 1'b0;
    end else begin
      upd_main_d    <= bus.upd_main_n;
      upd_second_d  <= bus.upd_second_n;
      upd_done_d    <= bus.upd_done_n;
      fall_main_q   <= upd_main_d   & ~bus.upd_main_n;
      fall_second_q <= upd_second_d & ~bus.upd_second_n;
      fall_done_q   <= upd_done_d   & ~bus.upd_done_n;
    end
  end

  // State register, sticky double-failure flag and delayed POR issue
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q     <= BIOS_MAIN;
      both_fail_q <= 1'b0;
      por_issue_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      por_issue_q <= por_issue;
      if (both_fail_set) begin
        both_fail_q <= 1'b1;
      end
    end
  end

  // Next-state logic; heartbeat loss outranks any update request
  always_comb begin
    state_d       = state_q;
    por_issue     = 1'b0;
    both_fail_set = 1'b0;
    case (state_q)
      BIOS_MAIN: begin
        if (boot_done && !hb_ok) begin
          state_d   = BIOS_SECOND;
          por_issue = 1'b1;
        end else if (boot_done && fall_second_q) begin
          state_d   = UPDATE_SECOND;
        end
      end
      BIOS_SECOND: begin
        if (boot_done && !hb_ok) begin
          both_fail_set = 1'b1;
        end else if (fall_main_q) begin
          state_d = UPDATE_MAIN;
        end
      end
      UPDATE_MAIN, UPDATE_SECOND: begin
        if (fall_done_q) begin
          state_d   = BIOS_MAIN;
          por_issue = 1'b1;
        end
      end
      default: state_d = BIOS_MAIN;
    endcase
  end

  // POR pulse generator; a new issue restarts the width count
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      por_rst_n_q <= 1'b1;
      por_cnt     <= 8'd0;
    end else if (por_issue_q) begin
      por_rst_n_q <= 1'b0;
      por_cnt     <= 8'd0;
    end else if (!por_rst_n_q) begin
      if (por_cnt == POR_MAX) begin
        por_rst_n_q <= 1'b1;
      end else if (bus.tick_1ms) begin
        por_cnt <= por_cnt + 8'd1;
      end
    end
  end

  // CS synchronizer; two high samples in a row mean the bus is idle
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      cs_s1 <= 1'b1;
      cs_s2 <= 1'b1;
      cs_s3 <= 1'b1;
    end else begin
      cs_s1 <= bus.qspi_csn_in;
      cs_s2 <= cs_s1;
      cs_s3 <= cs_s2;
    end
  end

  // Flash select follows the state only while the bus is idle
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      sel_req_q <= 1'b0;
      sel_q     <= 1'b0;
    end else begin
      sel_req_q <= state_q[0];
      if (cs_s2 && cs_s3) begin
        sel_q <= sel_req_q;
      end
    end
  end

  assign bus.qspi_csn0_out = sel_q ? 1'b1 : bus.qspi_csn_in;
  assign bus.qspi_csn1_out = sel_q ? bus.qspi_csn_in : 1'b1;
  assign bus.por_rst_n     = por_rst_n_q;
  assign bus.state         = state_q;
  assign bus.hb_ok         = hb_ok;
  assign bus.both_fail     = both_fail_q;

endmodule

// File: tb/tb_bios_boot_select_fsm.sv
// tb/tb_bios_boot_select_fsm.sv - directed self-checking bench for bios_boot_select_fsm
module tb_bios_boot_select_fsm;

  // 1 ms = 8 clks, 1 s = 25 ms = 200 clks
  localparam int MS_CLKS = 8;
  localparam int S_CLKS  = 200;

  logic clk;
  logic rst_l;
  int   n_tests;
  int   n_fail;
  int   cyc;
  bit   hb_run;

  bios_boot_select_fsm_if bif();

  bios_boot_select_fsm #(
    .BOOT_WAIT_S  (3),
    .HB_LOSS_MS   (20),
    .POR_PULSE_MS (5)
  ) dut (
    .clk   (clk),
    .rst_l (rst_l),
    .bus   (bif)
  );

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  // Tick generator
  initial begin
    cyc = 0;
    bif.tick_1ms = 1'b0;
    bif.tick_1s  = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      bif.tick_1ms = ((cyc % MS_CLKS) == MS_CLKS - 1);
      bif.tick_1s  = ((cyc % S_CLKS) == S_CLKS - 1);
    end
  end

  // Heartbeat generator: toggles every 10 ms while enabled, held low otherwise
  initial begin
    int div;
    div = 0;
    bif.hb_in = 1'b0;
    forever begin
      @(negedge clk);
      if (hb_run) begin
        if (div == 0) bif.hb_in = ~bif.hb_in;
        div = (div + 1) % (10 * MS_CLKS);
      end else begin
        div = 0;
        bif.hb_in = 1'b0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    hb_run           = 1'b0;
    bif.boot_arm     = 1'b0;
    bif.upd_main_n   = 1'b1;
    bif.upd_second_n = 1'b1;
    bif.upd_done_n   = 1'b1;
    bif.qspi_csn_in  = 1'b1;
    rst_l = 1'b0;
    repeat (4) @(negedge clk);
    rst_l = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_state(input logic [1:0] s, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (bif.state == s) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Measures the low width of a POR pulse that is already low at the current sample
  task automatic por_width(output int w);
    w = 1;
    while (w < 200) begin
      @(negedge clk);
      if (bif.por_rst_n == 1'b1) break;
      w++;
    end
  endtask

  initial begin
    bit ok;
    int bad_hb, bad_st, bad_por, w;

    n_tests = 0;
    n_fail  = 0;
    hb_run  = 1'b0;
    bif.boot_arm     = 1'b0;
    bif.upd_main_n   = 1'b1;
    bif.upd_second_n = 1'b1;
    bif.upd_done_n   = 1'b1;
    bif.qspi_csn_in  = 1'b1;
    rst_l = 1'b0;

    // 1. Reset state
    do_reset();
    chk("rst_state", bif.state, 0);
    chk("rst_por", bif.por_rst_n, 1);
    chk("rst_hb_ok", bif.hb_ok, 0);
    chk("rst_both_fail", bif.both_fail, 0);
    chk("rst_csn1", bif.qspi_csn1_out, 1);
    chk("rst_csn0_hi", bif.qspi_csn0_out, 1);
    bif.qspi_csn_in = 1'b0;
    #1;
    chk("rst_csn0_lo", bif.qspi_csn0_out, 0);
    chk("rst_csn1_lo", bif.qspi_csn1_out, 1);
    bif.qspi_csn_in = 1'b1;

    // 2. Heartbeat present for 10 s
    hb_run = 1'b1;
    bif.boot_arm = 1'b1;
    bad_hb = 0; bad_st = 0; bad_por = 0;
    for (int i = 0; i < 10 * S_CLKS; i++) begin
      @(negedge clk);
      if (i >= 5 && !bif.hb_ok) bad_hb++;
      if (bif.state != 2'd0) bad_st++;
      if (!bif.por_rst_n) bad_por++;
    end
    chk("hb_ok_low_clks", bad_hb, 0);
    chk("hb_state_moved", bad_st, 0);
    chk("hb_por_clks", bad_por, 0);

    // 3. Failover then double failure
    do_reset();
    bif.boot_arm = 1'b1;
    wait_state(2'd1, 1000, ok);
    chk("fo_reached", ok, 1);
    chk("fo_por_same_clk", bif.por_rst_n, 1);
    @(negedge clk);
    chk("fo_por_next_clk", bif.por_rst_n, 0);
    por_width(w);
    chk("fo_por_width", (w >= 33 && w <= 41), 1);
    bad_por = 0;
    ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (!bif.por_rst_n) bad_por++;
      if (bif.both_fail) begin
        ok = 1'b1;
        break;
      end
    end
    chk("bf_set", ok, 1);
    chk("bf_state", bif.state, 1);
    chk("bf_no_second_por", bad_por, 0);
    repeat (20) @(negedge clk);
    chk("bf_sticky", bif.both_fail, 1);

    // 4. Update second BIOS
    do_reset();
    hb_run = 1'b1;
    bif.boot_arm = 1'b1;
    repeat (S_CLKS) @(negedge clk);
    bif.upd_second_n = 1'b0;
    repeat (4) @(negedge clk);
    chk("upd_early_ignored", bif.state, 0);
    bif.upd_second_n = 1'b1;
    repeat (3 * S_CLKS) @(negedge clk);
    chk("upd_hb_ok", bif.hb_ok, 1);
    bif.upd_second_n = 1'b0;
    @(negedge clk);
    chk("upd_lat1", bif.state, 0);
    @(negedge clk);
    chk("upd_lat2", bif.state, 3);
    repeat (5) @(negedge clk);
    bif.qspi_csn_in = 1'b0;
    #1;
    chk("upd_csn1_routed", bif.qspi_csn1_out, 0);
    chk("upd_csn0_parked", bif.qspi_csn0_out, 1);
    @(negedge clk);
    bif.qspi_csn_in = 1'b1;
    repeat (4) @(negedge clk);
    bif.upd_second_n = 1'b1;
    bif.upd_done_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("done_state", bif.state, 0);
    chk("done_por_same_clk", bif.por_rst_n, 1);
    @(negedge clk);
    chk("done_por_low", bif.por_rst_n, 0);
    por_width(w);
    chk("done_por_width", (w >= 33 && w <= 41), 1);
    bif.upd_done_n = 1'b1;

    // 5. CS guard across a 0 -> 1 state change
    do_reset();
    bif.qspi_csn_in = 1'b0;
    bif.boot_arm = 1'b1;
    wait_state(2'd1, 1000, ok);
    chk("cs_fo_reached", ok, 1);
    bad_st = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (bif.qspi_csn0_out !== 1'b0 || bif.qspi_csn1_out !== 1'b1) bad_st++;
    end
    chk("cs_held_on_main", bad_st, 0);
    bif.qspi_csn_in = 1'b1;
    @(negedge clk);
    bif.qspi_csn_in = 1'b0;
    repeat (8) @(negedge clk);
    chk("cs_1clk_high_csn0", bif.qspi_csn0_out, 0);
    chk("cs_1clk_high_csn1", bif.qspi_csn1_out, 1);
    bif.qspi_csn_in = 1'b1;
    repeat (6) @(negedge clk);
    bif.qspi_csn_in = 1'b0;
    #1;
    chk("cs_switched_csn1", bif.qspi_csn1_out, 0);
    chk("cs_switched_csn0", bif.qspi_csn0_out, 1);
    bif.qspi_csn_in = 1'b1;

    // 6. Reset in the middle of a POR pulse
    do_reset();
    bif.boot_arm = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (!bif.por_rst_n) begin
        ok = 1'b1;
        break;
      end
    end
    chk("rp_por_started", ok, 1);
    repeat (2 * MS_CLKS) @(negedge clk);
    chk("rp_por_mid", bif.por_rst_n, 0);
    rst_l = 1'b0;
    #1;
    chk("rp_por_forced_hi", bif.por_rst_n, 1);
    chk("rp_state_main", bif.state, 0);
    bif.boot_arm = 1'b0;
    repeat (3) @(negedge clk);
    rst_l = 1'b1;
    bad_por = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!bif.por_rst_n) bad_por++;
    end
    chk("rp_no_por_on_exit", bad_por, 0);
    chk("rp_state_after", bif.state, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
